// File: rtl/q1_pkg.sv
// q1_pkg: shared types and constants for the q1 switch-conditioning slice.
//   state_e              - per-channel debounce FSM state (2-bit)
//   DEBOUNCE_CYCLES_DEF  - default number of consecutive equal samples to accept a level
package q1_pkg;

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_WAIT_HIGH = 2'd1,
    S_HIGH      = 2'd2,
    S_WAIT_LOW  = 2'd3
  } state_e;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000000;

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one switch bit -> synchronizer -> counter-based debounce FSM.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   sw_in      - raw asynchronous switch level
//   clean      - debounced level (registered)
//   rise/fall  - registered 1-cycle pulses aligned with the clean update
//   accept     - combinational: clean will change on the coming edge
//                (lets the top register chg_stb in the same cycle as rise/fall)
module debounce_channel
  import q1_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_in,
  output logic clean,
  output logic rise,
  output logic fall,
  output logic accept
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   clean_q, clean_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  // Bit 0 is the first stage; the top bit feeds the FSM.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], sw_in};
  assign sync   = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clean_d = clean_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      S_LOW: begin
        if (sync) begin
          state_d = S_WAIT_HIGH;
          cnt_d   = CNT_W'(1);
        end
      end
      S_WAIT_HIGH: begin
        if (!sync) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HIGH;
          cnt_d   = '0;
          clean_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HIGH: begin
        if (!sync) begin
          state_d = S_WAIT_LOW;
          cnt_d   = CNT_W'(1);
        end
      end
      S_WAIT_LOW: begin
        if (sync) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_LOW;
          cnt_d   = '0;
          clean_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      state_q <= S_LOW;
      cnt_q   <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign clean  = clean_q;
  assign rise   = rise_q;
  assign fall   = fall_q;
  assign accept = rise_d | fall_d;

endmodule

// File: rtl/q1_switch_debounce.sv
// q1_switch_debounce: conditions NUM_IN raw switches into clean levels {A,B,C,D}.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   sw_in     - raw asynchronous switch levels (bit 3=A .. bit 0=D)
//   sw_clean  - debounced levels
//   rise/fall - per-bit 1-cycle edge pulses on sw_clean
//   chg_stb   - 1-cycle pulse when any sw_clean bit changes
module q1_switch_debounce
  import q1_pkg::*;
#(
  parameter int unsigned NUM_IN          = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_IN-1:0] sw_in,
  output logic [NUM_IN-1:0] sw_clean,
  output logic [NUM_IN-1:0] rise,
  output logic [NUM_IN-1:0] fall,
  output logic              chg_stb
);

  logic [NUM_IN-1:0] accept;
  logic              chg_stb_q, chg_stb_d;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .sw_in (sw_in[i]),
      .clean (sw_clean[i]),
      .rise  (rise[i]),
      .fall  (fall[i]),
      .accept(accept[i])
    );
  end

  // Built from the channels' next-cycle pulses so the registered strobe
  // lands in the same cycle as rise/fall rather than one later.
  always_comb begin
    chg_stb_d = |accept;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chg_stb_q <= 1'b0;
    else     chg_stb_q <= chg_stb_d;
  end

  assign chg_stb = chg_stb_q;

endmodule

// File: tb/tb_q1_switch_debounce.sv
module tb_q1_switch_debounce;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw_in;
  logic [3:0] sw_clean, rise, fall;
  logic       chg_stb;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  q1_switch_debounce #(
    .NUM_IN         (4),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sw_in   (sw_in),
    .sw_clean(sw_clean),
    .rise    (rise),
    .fall    (fall),
    .chg_stb (chg_stb)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle 1 time unit for sampling/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance n edges, counting any pulse activity seen after each edge.
  task automatic run(input int n, output int pulses, output int strobes);
    pulses  = 0;
    strobes = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if ((rise | fall) != 4'b0) pulses++;
      if (chg_stb) strobes++;
    end
  endtask

  int p, s;

  initial begin
    rst   = 1'b1;
    sw_in = 4'b0000;
    tick();
    tick();
    check_eq("reset_clean", {28'b0, sw_clean}, 32'h0);
    check_eq("reset_pulses", {24'b0, rise, fall}, 32'h0);
    check_eq("reset_chg", {31'b0, chg_stb}, 32'h0);

    // 1: idle after release
    rst = 1'b0;
    run(20, p, s);
    check_eq("idle_clean", {28'b0, sw_clean}, 32'h0);
    check_eq("idle_pulses", p, 0);
    check_eq("idle_chg", s, 0);

    // 2: single rise on A, edge 0 = first tick
    sw_in = 4'b1000;
    run(5, p, s);
    check_eq("a_early_clean", {28'b0, sw_clean}, 32'h0);
    check_eq("a_early_pulses", p + s, 0);
    tick();
    check_eq("a_clean", {28'b0, sw_clean}, 32'h8);
    check_eq("a_rise", {28'b0, rise}, 32'h8);
    check_eq("a_fall", {28'b0, fall}, 32'h0);
    check_eq("a_chg", {31'b0, chg_stb}, 32'h1);
    tick();
    check_eq("a_rise_gone", {28'b0, rise}, 32'h0);
    check_eq("a_chg_gone", {31'b0, chg_stb}, 32'h0);
    check_eq("a_clean_hold", {28'b0, sw_clean}, 32'h8);

    // 3: bounce on B
    sw_in = 4'b1100; tick();
    sw_in = 4'b1000; tick();
    sw_in = 4'b1100; tick();
    sw_in = 4'b1000;
    run(12, p, s);
    check_eq("bounce_clean", {28'b0, sw_clean}, 32'h8);
    check_eq("bounce_pulses", p + s, 0);

    // back to 0000 (A falls)
    sw_in = 4'b0000;
    run(10, p, s);
    check_eq("a_fall_clean", {28'b0, sw_clean}, 32'h0);
    check_eq("a_fall_strobes", s, 1);

    // 4: three bits together
    sw_in = 4'b0111;
    run(5, p, s);
    check_eq("bcd_early_clean", {28'b0, sw_clean}, 32'h0);
    tick();
    check_eq("bcd_clean", {28'b0, sw_clean}, 32'h7);
    check_eq("bcd_rise", {28'b0, rise}, 32'h7);
    check_eq("bcd_chg", {31'b0, chg_stb}, 32'h1);
    run(10, p, s);
    check_eq("bcd_single_strobe", s, 0);
    check_eq("bcd_clean_hold", {28'b0, sw_clean}, 32'h7);

    // 5: all high, then all fall together
    sw_in = 4'b1111;
    run(10, p, s);
    check_eq("all_high_clean", {28'b0, sw_clean}, 32'hF);
    sw_in = 4'b0000;
    run(5, p, s);
    check_eq("all_fall_early", {28'b0, sw_clean}, 32'hF);
    tick();
    check_eq("all_fall", {28'b0, fall}, 32'hF);
    check_eq("all_fall_rise", {28'b0, rise}, 32'h0);
    check_eq("all_fall_clean", {28'b0, sw_clean}, 32'h0);
    check_eq("all_fall_chg", {31'b0, chg_stb}, 32'h1);

    // async reset in the middle of a pending change on bit 0
    sw_in = 4'b1110;
    run(10, p, s);
    check_eq("pre_rst_clean", {28'b0, sw_clean}, 32'hE);
    sw_in = 4'b1111;
    run(3, p, s);
    rst = 1'b1;
    #1;
    check_eq("async_rst_clean", {28'b0, sw_clean}, 32'h0);
    check_eq("async_rst_pulses", {24'b0, rise, fall}, 32'h0);
    check_eq("async_rst_chg", {31'b0, chg_stb}, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    run(5, p, s);
    check_eq("post_rst_early", {28'b0, sw_clean}, 32'h0);
    check_eq("post_rst_early_pulses", p + s, 0);
    tick();
    check_eq("post_rst_clean", {28'b0, sw_clean}, 32'hF);
    check_eq("post_rst_rise", {28'b0, rise}, 32'hF);
    check_eq("post_rst_chg", {31'b0, chg_stb}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
